// File: rtl/load_store_unit_if.sv
// load_store_unit_if: request/response handshake and data-memory port of the load/store unit
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] mem_A;
  logic        mem_WE;
  logic [31:0] mem_WriteData;
  logic [31:0] mem_ReadData;
  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_ReadData,
    input  req_ready, resp_valid, resp_err, resp_rdata, mem_A, mem_WE, mem_WriteData
  );
  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_ReadData,
    output req_ready, resp_valid, resp_err, resp_rdata, mem_A, mem_WE, mem_WriteData
  );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: bridges the memory stage to a word-indexed synchronous data memory
module load_store_unit #(
  parameter int AW = 8
) (
  input logic clk,
  input logic rst_n,
  load_store_unit_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0, RD = 2'd1, WR = 2'd2, RESP = 2'd3;
  logic [1:0] state, state_n;
  logic we, err, accept, bad;
  logic [2:0] f3;
  logic [AW+1:0] addr;
  logic [31:0] wdata, merged, loaded;
  logic [7:0] lane_b;
  logic [15:0] lane_h;
  assign accept = bus.req_valid && state == IDLE;
  assign bad = (bus.req_we ? (bus.req_funct3[2] || bus.req_funct3[1:0] == 2'b11)
                           : (bus.req_funct3[1:0] == 2'b11 || bus.req_funct3 == 3'b110))
            || (bus.req_funct3[1:0] == 2'b01 && bus.req_addr[0])
            || (bus.req_funct3[1:0] == 2'b10 && bus.req_addr[1:0] != 2'b00)
            || (|bus.req_addr[31:AW+2]);
  // full-word stores skip the read; sub-word stores read the old word first
  assign state_n = accept ? (bad ? RESP : (bus.req_we && bus.req_funct3 == 3'b010) ? WR : RD)
                 : state == RD ? (we ? WR : RESP)
                 : state == WR ? RESP
                 : IDLE;
  // state and request capture; reset aborts any access in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      we    <= 1'b0;
      err   <= 1'b0;
      f3    <= '0;
      addr  <= '0;
      wdata <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        we    <= bus.req_we;
        err   <= bad;
        f3    <= bus.req_funct3;
        addr  <= bus.req_addr[AW+1:0];
        wdata <= bus.req_wdata;
      end
    end
  end
  // little-endian merge of store data into the old word read back in WR
  always_comb begin
    merged = bus.mem_ReadData;
    if (f3[1:0] == 2'b00) merged[{addr[1:0], 3'b000} +: 8] = wdata[7:0];
    else if (f3[1:0] == 2'b01) merged[{addr[1], 4'b0000} +: 16] = wdata[15:0];
    else merged = wdata;
  end
  assign lane_b = bus.mem_ReadData[{addr[1:0], 3'b000} +: 8];
  assign lane_h = bus.mem_ReadData[{addr[1], 4'b0000} +: 16];
  assign loaded = f3[1:0] == 2'b00 ? {{24{lane_b[7] & ~f3[2]}}, lane_b}
                : f3[1:0] == 2'b01 ? {{16{lane_h[15] & ~f3[2]}}, lane_h}
                : bus.mem_ReadData;
  assign bus.req_ready     = state == IDLE;
  assign bus.resp_valid    = state == RESP;
  assign bus.resp_err      = state == RESP && err;
  assign bus.resp_rdata    = (state == RESP && !we && !err) ? loaded : '0;
  assign bus.mem_A         = {{(30-AW){1'b0}}, addr[AW+1:2]};
  assign bus.mem_WE        = state == WR;
  assign bus.mem_WriteData = state == WR ? merged : '0;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed and random accesses checked against a byte-level memory model
module tb_load_store_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int nvec = 0;
  int nbad = 0;
  logic [31:0] dmem [256];
  logic [31:0] rdq = '0;
  logic [7:0] rb [1024];
  logic [31:0] got;
  load_store_unit_if bus ();
  load_store_unit #(.AW(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  assign bus.mem_ReadData = rdq;
  // data memory: one-cycle registered read, word write enable
  always @(posedge clk) begin
    if (bus.mem_WE) dmem[bus.mem_A[7:0]] <= bus.mem_WriteData;
    rdq <= dmem[bus.mem_A[7:0]];
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nbad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  // reference: byte-addressed memory, RISC-V load/store semantics
  task automatic model(input bit we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                       output bit e, output logic [31:0] rd, output int lat, output int wcyc,
                       output logic [31:0] wword);
    int sz;
    bit legal;
    logic [31:0] base;
    sz = f3[1:0] == 2'd0 ? 1 : f3[1:0] == 2'd1 ? 2 : 4;
    legal = we ? (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2)
               : (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    e = !legal || (a % sz) != 0 || a >= 32'h400;
    rd = '0;
    lat = e ? 1 : (!we || sz == 4) ? 2 : 3;
    wcyc = (e || !we) ? 0 : sz == 4 ? 1 : 2;
    wword = '0;
    if (!e && !we) begin
      for (int i = 0; i < sz; i++) rd[8*i +: 8] = rb[a + i];
      if (!f3[2] && sz < 4 && rd[8*sz-1]) rd = rd | ~((32'd1 << (8*sz)) - 1);
    end
    if (!e && we) begin
      for (int i = 0; i < sz; i++) rb[a + i] = wd[8*i +: 8];
      base = a & 32'hFFFF_FFFC;
      wword = {rb[base+3], rb[base+2], rb[base+1], rb[base]};
    end
  endtask
  task automatic txn(input bit we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                     output logic [31:0] obs);
    bit e_x, e_g;
    logic [31:0] rd_x, ww_x, ww, wa;
    int lat_x, wc_x, lat, wes, wc;
    model(we, f3, a, wd, e_x, rd_x, lat_x, wc_x, ww_x);
    @(negedge clk);
    check("ready_idle", {31'd0, bus.req_ready}, 32'd1);
    bus.req_valid = 1'b1;
    bus.req_we = we;
    bus.req_funct3 = f3;
    bus.req_addr = a;
    bus.req_wdata = wd;
    @(posedge clk);
    lat = 0; wes = 0; wc = 0; ww = '0; wa = '0; e_g = 1'b0; obs = '0;
    for (int c = 1; c <= 8 && lat == 0; c++) begin
      @(negedge clk);
      if (c == 1) begin
        bus.req_valid = 1'b0;
        check("ready_busy", {31'd0, bus.req_ready}, 32'd0);
      end
      if (bus.mem_WE) begin
        wes++; wc = c; ww = bus.mem_WriteData; wa = bus.mem_A;
      end
      if (bus.resp_valid) begin
        lat = c; e_g = bus.resp_err; obs = bus.resp_rdata;
      end
    end
    check("latency", lat, lat_x);
    check("err", {31'd0, e_g}, {31'd0, e_x});
    check("rdata", obs, rd_x);
    check("we_count", wes, wc_x != 0 ? 1 : 0);
    if (wc_x != 0) begin
      check("we_cycle", wc, wc_x);
      check("wdata", ww, ww_x);
      check("waddr", wa, {22'd0, a[9:2]});
    end
  endtask
  initial begin
    logic [31:0] w, a;
    logic [2:0] f3;
    bit we;
    for (int i = 0; i < 256; i++) begin
      w = i == 4 ? 32'h8765_43F1 : $urandom;
      dmem[i] = w;
      for (int k = 0; k < 4; k++) rb[4*i + k] = w[8*k +: 8];
    end
    bus.req_valid = 1'b0;
    bus.req_we = 1'b0;
    bus.req_funct3 = '0;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", {31'd0, bus.req_ready}, 32'd1);
    check("rst_rvalid", {31'd0, bus.resp_valid}, 32'd0);
    check("rst_rerr", {31'd0, bus.resp_err}, 32'd0);
    check("rst_rdata", bus.resp_rdata, 32'd0);
    check("rst_A", bus.mem_A, 32'd0);
    check("rst_WE", {31'd0, bus.mem_WE}, 32'd0);
    check("rst_WD", bus.mem_WriteData, 32'd0);
    rst_n = 1'b1;
    txn(0, 3'b010, 32'h10, 0, got); check("LW10", got, 32'h8765_43F1);
    txn(0, 3'b000, 32'h10, 0, got); check("LB10", got, 32'hFFFF_FFF1);
    txn(0, 3'b100, 32'h13, 0, got); check("LBU13", got, 32'h0000_0087);
    txn(0, 3'b001, 32'h12, 0, got); check("LH12", got, 32'hFFFF_8765);
    txn(0, 3'b101, 32'h10, 0, got); check("LHU10", got, 32'h0000_43F1);
    txn(1, 3'b000, 32'h11, 32'h0000_00AB, got);
    txn(0, 3'b010, 32'h10, 0, got); check("LW10_after_SB", got, 32'h8765_ABF1);
    txn(1, 3'b010, 32'h20, 32'hDEAD_BEEF, got);
    txn(0, 3'b010, 32'h20, 0, got); check("LW20", got, 32'hDEAD_BEEF);
    txn(0, 3'b010, 32'h12, 0, got);
    txn(1, 3'b001, 32'h13, 32'h1234, got);
    txn(0, 3'b011, 32'h10, 0, got);
    txn(0, 3'b010, 32'h400, 0, got);
    // reset in the middle of a sub-word store's write cycle
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = 3'b000;
    bus.req_addr = 32'h12; bus.req_wdata = 32'h55;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    check("WR_before_rst", {31'd0, bus.mem_WE}, 32'd1);
    #2 rst_n = 1'b0;
    #1 check("WE_async_drop", {31'd0, bus.mem_WE}, 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("no_resp_rst", {31'd0, bus.resp_valid}, 32'd0);
    end
    rst_n = 1'b1;
    #1 check("ready_after_rst", {31'd0, bus.req_ready}, 32'd1);
    txn(0, 3'b010, 32'h10, 0, got); check("LW10_after_abort", got, 32'h8765_ABF1);
    for (int n = 0; n < 300; n++) begin
      we = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      a = $urandom_range(0, 1023);
      if ($urandom_range(0, 3) != 0) a = a & 32'h3FC;
      if ($urandom_range(0, 15) == 0) a = $urandom;
      txn(we, f3, a, $urandom, got);
    end
    for (int i = 0; i < 256; i++)
      check("mem_image", dmem[i], {rb[4*i+3], rb[4*i+2], rb[4*i+1], rb[4*i]});
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
endmodule
